// File: rtl/count_dir_monitor.sv
// count_dir_monitor
// Watches the value bus of an up/down counter and recovers its counting
// direction. Each strobed sample is classified against the previous one
// (up, down, hold, jump, all modulo 2^WIDTH). After LOCK_CNT consecutive
// same-direction steps the monitor locks. While locked it tracks legal
// direction reversals and flags jumps with a one-cycle step_err pulse.
//
// Optional feature: define COUNT_DIR_MONITOR_ERRCNT_EN to build the
// saturating err_count register. Without it, err_count is tied to 0.
//
// state  | meaning
// S_IDLE | no previous sample captured yet
// S_ACQ  | building a run of same-direction steps toward lock
// S_LOCK | direction locked; reversals flip dir_up, jumps raise step_err

module count_dir_monitor #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 4,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [WIDTH-1:0]    count,
  output logic                dir_up,
  output logic                locked,
  output logic                step_err,
  output logic [ERRCNT_W-1:0] err_count
);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("count_dir_monitor: WIDTH must be at least 2");
    end
    if ((LOCK_CNT < 1) || (LOCK_CNT > 15)) begin : g_bad_lock_cnt
      $error("count_dir_monitor: LOCK_CNT must be in 1..15");
    end
    if (ERRCNT_W < 1) begin : g_bad_errcnt_w
      $error("count_dir_monitor: ERRCNT_W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_JUMP = 2'd3
  } step_t;

  // run_cnt is 4 bits wide, so the lock threshold always fits
  localparam logic [3:0] LOCK_THR = 4'(LOCK_CNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       run_cnt_q, run_cnt_d;
  logic             run_dir_q, run_dir_d;
  logic             dir_up_d;
  logic             locked_d;
  logic             step_err_d;
  logic             err_inc;

  step_t            step;
  logic [WIDTH-1:0] prev_plus;
  logic [WIDTH-1:0] prev_minus;
  logic             step_move;
  logic             step_dir;
  logic             run_cont;
  logic [3:0]       run_cnt_step;

  // neighbours of the previous sample; arithmetic wraps at 2^WIDTH
  assign prev_plus  = prev_q + WIDTH'(1);
  assign prev_minus = prev_q - WIDTH'(1);

  // classify the incoming sample against the previous one
  always_comb begin
    step = STEP_JUMP;
    if (count == prev_q) begin
      step = STEP_HOLD;
    end else if (count == prev_plus) begin
      step = STEP_UP;
    end else if (count == prev_minus) begin
      step = STEP_DOWN;
    end
  end

  assign step_move = (step == STEP_UP) || (step == STEP_DOWN);
  assign step_dir  = (step == STEP_UP);

  // an empty run accepts either direction; a reversal restarts the run at 1
  assign run_cont     = (run_cnt_q == 4'd0) || (step_dir == run_dir_q);
  assign run_cnt_step = run_cont ? (run_cnt_q + 4'd1) : 4'd1;

  // next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_cnt_d  = run_cnt_q;
    run_dir_d  = run_dir_q;
    dir_up_d   = dir_up;
    locked_d   = locked;
    step_err_d = 1'b0;
    err_inc    = 1'b0;

    if (valid) begin
      prev_d = count;

      unique case (state_q)
        S_IDLE: begin
          run_cnt_d = 4'd0;
          state_d   = S_ACQ;
        end

        S_ACQ: begin
          if (step_move) begin
            run_cnt_d = run_cnt_step;
            run_dir_d = step_dir;
            if (run_cnt_step == LOCK_THR) begin
              state_d  = S_LOCK;
              dir_up_d = step_dir;
              locked_d = 1'b1;
            end
          end else if (step == STEP_JUMP) begin
            // jumps before lock only restart acquisition, no error
            run_cnt_d = 4'd0;
          end
        end

        S_LOCK: begin
          if (step_move) begin
            // a reversal is a legal direction change of the counter
            dir_up_d = step_dir;
          end else if (step == STEP_JUMP) begin
            step_err_d = 1'b1;
            err_inc    = 1'b1;
            locked_d   = 1'b0;
            run_cnt_d  = 4'd0;
            state_d    = S_ACQ;
          end
        end

        default: begin
          state_d   = S_IDLE;
          run_cnt_d = 4'd0;
          locked_d  = 1'b0;
        end
      endcase
    end
  end

  // state, sample history and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      prev_q    <= '0;
      run_cnt_q <= 4'd0;
      run_dir_q <= 1'b0;
      dir_up    <= 1'b0;
      locked    <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      run_cnt_q <= run_cnt_d;
      run_dir_q <= run_dir_d;
      dir_up    <= dir_up_d;
      locked    <= locked_d;
      step_err  <= step_err_d;
    end
  end

`ifdef COUNT_DIR_MONITOR_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count_q;

  // saturating count of step_err pulses; holds at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else if (err_inc && (err_count_q != {ERRCNT_W{1'b1}})) begin
      err_count_q <= err_count_q + ERRCNT_W'(1);
    end
  end

  assign err_count = err_count_q;
`else
  logic unused_err_inc;

  assign unused_err_inc = err_inc;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_count_dir_monitor.sv
// Self-checking bench for count_dir_monitor. A behavioural reference model
// works on integer differences modulo 2^WIDTH and predicts every output.
// A second instance with ERRCNT_W=2 covers err_count saturation.
`timescale 1ns/1ps

module tb_count_dir_monitor;

  localparam int W    = 3;
  localparam int LOCK = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] count = '0;

  logic         dir_up, locked, step_err;
  logic [7:0]   err_count;
  logic         sat_dir_up, sat_locked, sat_step_err;
  logic [1:0]   sat_err_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_mode;   // 0 no history, 1 acquiring, 2 locked
  int m_prev;
  int m_run;
  bit m_rdir;
  bit m_dir;
  bit m_err;
  int m_errs;

  count_dir_monitor #(.WIDTH(W), .LOCK_CNT(LOCK), .ERRCNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid(valid), .count(count),
    .dir_up(dir_up), .locked(locked), .step_err(step_err),
    .err_count(err_count)
  );

  count_dir_monitor #(.WIDTH(W), .LOCK_CNT(LOCK), .ERRCNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .valid(valid), .count(count),
    .dir_up(sat_dir_up), .locked(sat_locked), .step_err(sat_step_err),
    .err_count(sat_err_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_errcnt(input int sat_max);
`ifdef COUNT_DIR_MONITOR_ERRCNT_EN
    return (m_errs > sat_max) ? sat_max : m_errs;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_run = 0;
    m_rdir = 0; m_dir = 0; m_err = 0; m_errs = 0;
  endtask

  task automatic model_step(input bit v, input int c);
    int d;
    bit sdir;
    m_err = 0;
    if (v) begin
      d = (c - m_prev) & MASK;
      sdir = (d == 1);
      if (m_mode == 0) begin
        m_run  = 0;
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == 1 || d == MASK) begin
          if (m_run == 0 || sdir == m_rdir) m_run = m_run + 1;
          else m_run = 1;
          m_rdir = sdir;
          if (m_run == LOCK) begin
            m_mode = 2;
            m_dir  = sdir;
          end
        end else if (d != 0) begin
          m_run = 0;
        end
      end else begin
        if (d == 1 || d == MASK) begin
          m_dir = sdir;
        end else if (d != 0) begin
          m_err  = 1;
          m_mode = 1;
          m_run  = 0;
          m_errs = m_errs + 1;
        end
      end
      m_prev = c;
    end
  endtask

  task automatic compare_all();
    check_val("locked", locked, (m_mode == 2));
    check_val("step_err", step_err, m_err);
    if (m_mode == 2) check_val("dir_up", dir_up, m_dir);
    check_val("err_count", err_count, exp_errcnt(255));
    check_val("sat_locked", sat_locked, (m_mode == 2));
    check_val("sat_err_count", sat_err_count, exp_errcnt(3));
  endtask

  task automatic drive(input bit v, input int c);
    @(negedge clk);
    valid = v;
    count = W'(c & MASK);
    @(posedge clk);
    model_step(v, c & MASK);
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_locked"}, locked, 0);
    check_val({tag, "_dir_up"}, dir_up, 0);
    check_val({tag, "_step_err"}, step_err, 0);
    check_val({tag, "_err_count"}, err_count, 0);
    check_val({tag, "_sat_err_count"}, sat_err_count, 0);
  endtask

  // reset asserted between edges; outputs must clear before the next edge
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all_zero(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int seq[$];
    bit rdir;
    int nxt;
    int r;

    model_reset();
    #3;
    check_all_zero("por");
    @(negedge clk);
    reset = 1'b0;

    // up lock with wrap
    for (int c = 0; c <= 3; c++) drive(1, c);
    check_val("up_not_locked_at3", locked, 0);
    drive(1, 4);
    check_val("up_locked_at4", locked, 1);
    check_val("up_dir", dir_up, 1);
    for (int c = 5; c <= 9; c++) begin
      drive(1, c);
      check_val("up_wrap_no_err", step_err, 0);
    end
    check_val("up_still_locked", locked, 1);

    // down lock with wrap
    async_reset("rst_a");
    seq = '{5, 4, 3, 2};
    foreach (seq[i]) drive(1, seq[i]);
    check_val("dn_not_locked_at2", locked, 0);
    drive(1, 1);
    check_val("dn_locked_at1", locked, 1);
    check_val("dn_dir", dir_up, 0);
    drive(1, 0);
    drive(1, 7);
    check_val("dn_wrap_no_err", step_err, 0);
    check_val("dn_wrap_locked", locked, 1);

    // reversal and holds while locked
    async_reset("rst_b");
    seq = '{7, 0, 1, 2, 3};
    foreach (seq[i]) drive(1, seq[i]);
    check_val("rev_locked_at3", locked, 1);
    drive(1, 3);
    drive(1, 3);
    check_val("rev_hold_dir", dir_up, 1);
    drive(1, 2);
    check_val("rev_dir_flip", dir_up, 0);
    check_val("rev_locked", locked, 1);
    check_val("rev_no_err", step_err, 0);
    drive(1, 1);
    check_val("rev_dir_down", dir_up, 0);

    // illegal jump while locked
    async_reset("rst_c");
    seq = '{6, 7, 0, 1, 2};
    foreach (seq[i]) drive(1, seq[i]);
    check_val("jmp_locked_at2", locked, 1);
    drive(1, 6);
    check_val("jmp_step_err", step_err, 1);
    check_val("jmp_unlocked", locked, 0);
`ifdef COUNT_DIR_MONITOR_ERRCNT_EN
    check_val("jmp_err_count", err_count, 1);
`else
    check_val("jmp_err_count_off", err_count, 0);
`endif
    drive(1, 6);
    check_val("jmp_pulse_one_cycle", step_err, 0);

    // saturation: five jumps, each after a re-lock
    async_reset("rst_d");
    drive(1, 0);
    for (int k = 0; k < 5; k++) begin
      for (int c = 1; c <= 4; c++) drive(1, c);
      check_val("sat_relock", locked, 1);
      drive(1, 0);
      check_val("sat_jump_err", step_err, 1);
    end
`ifdef COUNT_DIR_MONITOR_ERRCNT_EN
    check_val("sat_final_w2", sat_err_count, 3);
    check_val("sat_final_w8", err_count, 5);
`else
    check_val("sat_final_off", sat_err_count, 0);
`endif

    // random walk with strobe gaps; idle cycles carry random values
    async_reset("rst_e");
    rdir = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(0, int'($urandom_range(0, MASK)));
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 70)      nxt = rdir ? m_prev + 1 : m_prev - 1;
        else if (r < 80) nxt = m_prev;
        else if (r < 90) begin
          rdir = ~rdir;
          nxt = rdir ? m_prev + 1 : m_prev - 1;
        end else         nxt = int'($urandom_range(0, MASK));
        drive(1, nxt & MASK);
      end
    end

    // asynchronous reset while locked, then a fresh lock
    async_reset("rst_f");
    for (int c = 2; c <= 6; c++) drive(1, c);
    check_val("pre_rst_locked", locked, 1);
    async_reset("rst_locked");
    for (int c = 3; c <= 6; c++) drive(1, c);
    check_val("post_rst_not_locked", locked, 0);
    drive(1, 7);
    check_val("post_rst_locked", locked, 1);
    check_val("post_rst_dir", dir_up, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
